// File: rtl/lr3_disp_pkg.sv
// Shared constants and types for the 8-digit 7-segment scan controller.
package lr3_disp_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIG_W      = 3;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns, entry 15 first.
    localparam logic [15:0][SEG_W-1:0] SEG7_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/lr3_disp_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg7
    import lr3_disp_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = SEG7_LUT[nibble];

endmodule

// File: rtl/lr3_disp_scan_ctrl.sv
// Round-robin digit scanner with per-slot blank gap and per-frame input snapshot.
module lr3_disp_scan_ctrl
    import lr3_disp_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_DIGITS*NIB_W-1:0]   DISP_SEQ,
    input  logic [NUM_DIGITS-1:0]         DISP_OFF,
    output logic [NUM_DIGITS-1:0]         AN,
    output logic [SEG_W-1:0]              SEG,
    output logic                          FRAME_TICK
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]                cnt, cnt_nxt;
    logic [DIG_W-1:0]                dig, dig_nxt;
    logic [NUM_DIGITS*NIB_W-1:0]     snap_seq, snap_seq_nxt;
    logic [NUM_DIGITS-1:0]           snap_off, snap_off_nxt;
    scan_state_e                     state, state_nxt;
    logic                            wrap_q, wrap_nxt;
    logic [NUM_DIGITS-1:0]           an_nxt;
    logic [SEG_W-1:0]                seg_nxt;
    logic                            tick_nxt;
    logic [SEG_W-1:0]                dec_seg_c;

    hex_to_seg7 u_dec (
        .nibble (snap_seq[{dig, 2'b00} +: NIB_W]),
        .seg_c  (dec_seg_c)
    );

    // Registers; reset also captures the inputs as the first frame's snapshot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= '0;
            dig        <= '0;
            state      <= ST_BLANK;
            wrap_q     <= 1'b0;
            snap_seq   <= DISP_SEQ;
            snap_off   <= DISP_OFF;
            AN         <= '1;
            SEG        <= SEG_BLANK;
            FRAME_TICK <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            dig        <= dig_nxt;
            state      <= state_nxt;
            wrap_q     <= wrap_nxt;
            snap_seq   <= snap_seq_nxt;
            snap_off   <= snap_off_nxt;
            AN         <= an_nxt;
            SEG        <= seg_nxt;
            FRAME_TICK <= tick_nxt;
        end
    end

    // Scan counter, blank/drive decision and output selection.
    always_comb begin
        cnt_nxt      = cnt + CNT_W'(1);
        dig_nxt      = dig;
        snap_seq_nxt = snap_seq;
        snap_off_nxt = snap_off;
        an_nxt       = '1;
        seg_nxt      = SEG_BLANK;
        wrap_nxt     = (cnt == CNT_MAX) && (dig == DIG_MAX);
        tick_nxt     = wrap_q;

        if (cnt == CNT_MAX) begin
            cnt_nxt = '0;
            dig_nxt = dig + DIG_W'(1);
        end

        if (wrap_nxt) begin
            snap_seq_nxt = DISP_SEQ;
            snap_off_nxt = DISP_OFF;
        end

        // State tracks the slot position the counter is about to hold.
        state_nxt = (32'(cnt_nxt) < BLANK_CYC) ? ST_BLANK : ST_DRIVE;

        if ((state == ST_DRIVE) && !snap_off[dig]) begin
            an_nxt  = ~(NUM_DIGITS'(1) << dig);
            seg_nxt = dec_seg_c;
        end
    end

endmodule

// File: tb/tb_lr3_disp_scan_ctrl.sv
// Randomized and directed bench for lr3_disp_scan_ctrl against a slot-position model.
module tb_lr3_disp_scan_ctrl;

    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = DIV * 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] seq = 32'h0;
    logic [7:0]  off = 8'h0;

    logic [7:0]  an_b1, an_b0;
    logic [6:0]  seg_b1, seg_b0;
    logic        tick_b1, tick_b0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state per instance: index 0 is BLANK_CYC=1, index 1 is BLANK_CYC=0.
    int          m_p   [2];
    logic [31:0] m_seq [2];
    logic [7:0]  m_off [2];
    logic [7:0]  e_an  [2];
    logic [6:0]  e_seg [2];
    logic        e_tick[2];
    int          blk   [2] = '{1, 0};

    always #5 clk = ~clk;

    lr3_disp_scan_ctrl #(.CLK_DIV(DIV), .BLANK_CYC(1)) u_b1 (
        .CLK(clk), .RST(rst), .DISP_SEQ(seq), .DISP_OFF(off),
        .AN(an_b1), .SEG(seg_b1), .FRAME_TICK(tick_b1)
    );

    lr3_disp_scan_ctrl #(.CLK_DIV(DIV), .BLANK_CYC(0)) u_b0 (
        .CLK(clk), .RST(rst), .DISP_SEQ(seq), .DISP_OFF(off),
        .AN(an_b0), .SEG(seg_b0), .FRAME_TICK(tick_b0)
    );

    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_p[i]   = 0;
                m_seq[i] = seq;
                m_off[i] = off;
                e_an[i]  = 8'hFF;
                e_seg[i] = 7'h7F;
                e_tick[i] = 1'b0;
            end else begin
                int          c, d;
                logic [31:0] tmp;
                c = m_p[i] % DIV;
                d = (m_p[i] / DIV) % 8;
                e_an[i]  = 8'hFF;
                e_seg[i] = 7'h7F;
                if (!((c < blk[i]) || (m_p[i] == 0) || m_off[i][d])) begin
                    e_an[i][d] = 1'b0;
                    tmp = m_seq[i] >> (4 * d);
                    e_seg[i] = seg_ref(tmp[3:0]);
                end
                e_tick[i] = (m_p[i] > 0) && (m_p[i] % FRAME == 0);
                if (m_p[i] % FRAME == FRAME - 1) begin
                    m_seq[i] = seq;
                    m_off[i] = off;
                end
                m_p[i]++;
            end
        end
    endtask

    task automatic check_inst(input string tag, input int i, input logic [7:0] an,
                              input logic [6:0] seg, input logic tk);
        n_cmp++;
        assert (an === e_an[i]) else begin
            n_fail++;
            $error("FAIL %s_an p=%0d observed=%h expected=%h", tag, m_p[i], an, e_an[i]);
        end
        n_cmp++;
        assert (seg === e_seg[i]) else begin
            n_fail++;
            $error("FAIL %s_seg p=%0d observed=%h expected=%h", tag, m_p[i], seg, e_seg[i]);
        end
        n_cmp++;
        assert (tk === e_tick[i]) else begin
            n_fail++;
            $error("FAIL %s_tick p=%0d observed=%b expected=%b", tag, m_p[i], tk, e_tick[i]);
        end
        n_cmp++;
        assert ($countones(~an) <= 1) else begin
            n_fail++;
            $error("FAIL %s_onehot p=%0d observed=%h expected=at_most_one_low", tag, m_p[i], an);
        end
    endtask

    // One clock: model at the rising edge, DUT comparison at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_inst("b1", 0, an_b1, seg_b1, tick_b1);
        check_inst("b0", 1, an_b0, seg_b0, tick_b0);
    endtask

    function automatic int cur_dig();
        return (m_p[0] / DIV) % 8;
    endfunction

    initial begin
        // Reset hold with a static value pending
        rst = 1'b1;
        seq = 32'h76543210;
        off = 8'h00;
        repeat (5) step();

        // Static value for two frames
        rst = 1'b0;
        repeat (2 * FRAME) step();

        // Blanking mask
        seq = 32'hFEDCBA98;
        off = 8'hF0;
        repeat (2 * FRAME + 3) step();

        // Mid-frame change lands during digit 3
        seq = 32'h0;
        off = 8'h00;
        repeat (FRAME + 2) step();
        for (int k = 0; k < FRAME && cur_dig() != 3; k++) step();
        seq = 32'h22222222;
        repeat (2 * FRAME) step();

        // One-cycle reset during digit 5
        for (int k = 0; k < FRAME && cur_dig() != 5; k++) step();
        step();
        rst = 1'b1;
        seq = 32'h89ABCDEF;
        step();
        rst = 1'b0;
        repeat (FRAME + 8) step();

        // Random inputs with occasional resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) seq = $urandom();
            if ($urandom_range(0, 15) == 0) off = 8'($urandom());
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        repeat (FRAME) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
